// File: rtl/drain_counter.sv
// drain_counter: drains an index from a start value down to a floor, one step
// per enabled cycle, never exceeding a fixed ceiling. Supports restart via a
// load handshake, reports rejected loads, and keeps a sticky invariant flag.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_RUN  | draining; i decrements while selector=1 and i > floor
// S_DONE | i reached floor; holds until an acceptable load restarts it
module drain_counter #(
  parameter int WIDTH     = 15,
  parameter int RST_START = 450,
  parameter int RST_FLOOR = 0,
  parameter int CEILING   = 500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             selector,
  input  logic             load,
  input  logic [WIDTH-1:0] load_start,
  input  logic [WIDTH-1:0] load_floor,
  output logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] floor,
  output logic             busy,
  output logic             done,
  output logic             load_err,
  output logic [WIDTH-1:0] steps,
  output logic             viol
);

  localparam logic [WIDTH-1:0] C_CEIL      = WIDTH'(CEILING);
  localparam logic [WIDTH-1:0] C_RST_START = WIDTH'(RST_START);
  localparam logic [WIDTH-1:0] C_RST_FLOOR = WIDTH'(RST_FLOOR);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_DONE = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] r_floor;
  logic [WIDTH-1:0] r_steps;
  logic             r_load_err;
  logic             r_viol;

  logic w_can_dec;
  logic w_last_dec;
  logic w_load_ok;
  logic w_steps_sat;
  logic w_over_ceil;

  // The decrement is gated on i > floor, so i can never wrap below floor.
  assign w_can_dec   = selector && (r_i > r_floor);
  assign w_last_dec  = (r_i - 1'b1) == r_floor;
  assign w_load_ok   = (load_start <= C_CEIL) && (load_floor <= load_start);
  assign w_steps_sat = &r_steps;
  assign w_over_ceil = r_i > C_CEIL;

  // Main sequencer: index, floor, step count, load error pulse and sticky flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_i        <= C_RST_START;
      r_floor    <= C_RST_FLOOR;
      r_steps    <= '0;
      r_load_err <= 1'b0;
      r_viol     <= 1'b0;
    end else begin
      r_load_err <= 1'b0;
      r_viol     <= r_viol | w_over_ceil;
      case (r_state)
        S_RUN: begin
          // Loads are not honoured mid-drain; flag them and keep counting.
          if (load) begin
            r_load_err <= 1'b1;
          end
          if (w_can_dec) begin
            r_i <= r_i - 1'b1;
            if (!w_steps_sat) begin
              r_steps <= r_steps + 1'b1;
            end
            if (w_last_dec) begin
              r_state <= S_DONE;
            end
          end else if (r_i <= r_floor) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          // selector is ignored here, so a load always wins over a step.
          if (load) begin
            if (w_load_ok) begin
              r_i     <= load_start;
              r_floor <= load_floor;
              r_steps <= '0;
              r_state <= S_RUN;
            end else begin
              r_load_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign i        = r_i;
  assign floor    = r_floor;
  assign steps    = r_steps;
  assign load_err = r_load_err;
  assign viol     = r_viol;
  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_drain_counter.sv
// Bench for drain_counter: directed scenarios followed by a random phase, all
// compared every cycle against an integer-level behavioural model.
module tb_drain_counter;

  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         selector = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_start = '0;
  logic [W-1:0] load_floor = '0;
  logic [W-1:0] i;
  logic [W-1:0] floor;
  logic         busy;
  logic         done;
  logic         load_err;
  logic [W-1:0] steps;
  logic         viol;

  drain_counter #(
    .WIDTH(W), .RST_START(450), .RST_FLOOR(0), .CEILING(500)
  ) dut (
    .clk(clk), .rst(rst), .selector(selector), .load(load),
    .load_start(load_start), .load_floor(load_floor),
    .i(i), .floor(floor), .busy(busy), .done(done),
    .load_err(load_err), .steps(steps), .viol(viol)
  );

  always #5 clk = ~clk;

  // Behavioural reference: plain integers and a done flag.
  int    m_i = 450;
  int    m_floor = 0;
  int    m_steps = 0;
  bit    m_done = 1'b0;
  bit    m_err = 1'b0;

  int    n_pass = 0;
  int    n_total = 0;
  string scen = "init";

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: got %0d expected %0d", scen, tag, obs, exp);
  endtask

  task automatic model_edge(input bit r, input bit s, input bit ld, input int ls, input int lf);
    if (r) begin
      m_i = 450; m_floor = 0; m_steps = 0; m_done = 1'b0; m_err = 1'b0;
    end else if (!m_done) begin
      m_err = ld;
      if (s && m_i > m_floor) begin
        m_i = m_i - 1;
        m_steps = (m_steps >= 32767) ? 32767 : m_steps + 1;
      end
      if (m_i <= m_floor) m_done = 1'b1;
    end else begin
      m_err = 1'b0;
      if (ld) begin
        if (ls <= 500 && lf <= ls) begin
          m_i = ls; m_floor = lf; m_steps = 0; m_done = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("i",        {17'd0, i},      m_i);
    chk("floor",    {17'd0, floor},  m_floor);
    chk("steps",    {17'd0, steps},  m_steps);
    chk("busy",     {31'd0, busy},   {31'd0, !m_done});
    chk("done",     {31'd0, done},   {31'd0, m_done});
    chk("load_err", {31'd0, load_err}, {31'd0, m_err});
    chk("viol",     {31'd0, viol},   32'd0);
  endtask

  task automatic step(input bit r, input bit s, input bit ld, input int ls = 0, input int lf = 0);
    @(negedge clk);
    rst = r; selector = s; load = ld;
    load_start = W'(ls); load_floor = W'(lf);
    @(posedge clk);
    model_edge(r, s, ld, ls, lf);
    #1;
    check_all();
  endtask

  initial begin
    int ls;
    int lf;

    scen = "reset_idle";
    step(1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 0, 0);
    chk("idle_i", {17'd0, i}, 450);

    scen = "toggle";
    step(1, 0, 0);
    for (int k = 0; k < 20; k++) step(0, (k % 2) == 0, 0);
    chk("toggle_i", {17'd0, i}, 440);
    chk("toggle_steps", {17'd0, steps}, 10);

    scen = "full_drain";
    step(1, 0, 0);
    for (int k = 0; k < 450; k++) step(0, 1, 0);
    chk("drain_i", {17'd0, i}, 0);
    chk("drain_done", {31'd0, done}, 1);
    chk("drain_steps", {17'd0, steps}, 450);
    for (int k = 0; k < 5; k++) step(0, 1, 0);
    chk("nowrap_i", {17'd0, i}, 0);

    scen = "load_10_7";
    step(0, 1, 1, 10, 7);
    chk("load_i", {17'd0, i}, 10);
    for (int k = 0; k < 3; k++) step(0, 1, 0);
    chk("l107_i", {17'd0, i}, 7);
    chk("l107_done", {31'd0, done}, 1);
    chk("l107_steps", {17'd0, steps}, 3);

    scen = "reject_done";
    step(0, 1, 1, 600, 0);
    chk("rej600_err", {31'd0, load_err}, 1);
    chk("rej600_i", {17'd0, i}, 7);
    step(0, 0, 0);
    step(0, 1, 1, 5, 9);
    chk("rej59_err", {31'd0, load_err}, 1);
    step(0, 0, 0);
    chk("rej_clear", {31'd0, load_err}, 0);

    scen = "reject_run";
    step(0, 0, 1, 100, 50);
    step(0, 1, 1, 3, 1);
    chk("runrej_err", {31'd0, load_err}, 1);
    chk("runrej_i", {17'd0, i}, 99);
    step(0, 1, 0);
    for (int k = 0; k < 48; k++) step(0, 1, 0);
    chk("runrej_done", {31'd0, done}, 1);

    scen = "start_eq_floor";
    step(0, 0, 1, 20, 20);
    chk("eq_busy", {31'd0, busy}, 1);
    step(0, 0, 0);
    chk("eq_done", {31'd0, done}, 1);
    chk("eq_steps", {17'd0, steps}, 0);

    scen = "reset_mid_run";
    step(1, 0, 0);
    for (int k = 0; k < 327; k++) step(0, 1, 0);
    chk("at123", {17'd0, i}, 123);
    step(1, 1, 1, 10, 5);
    chk("rr_i", {17'd0, i}, 450);
    chk("rr_steps", {17'd0, steps}, 0);

    scen = "reset_mid_done";
    for (int k = 0; k < 450; k++) step(0, 1, 0);
    for (int k = 0; k < int'($urandom_range(1, 10)); k++) step(0, $urandom_range(0, 1), 0);
    step(1, 1, 1, 10, 5);
    chk("rd_i", {17'd0, i}, 450);
    chk("rd_busy", {31'd0, busy}, 1);

    scen = "random";
    step(0, 0, 1, 30, 10);
    for (int k = 0; k < 500; k++) begin
      ls = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 600));
      lf = $urandom_range(0, ls + 20);
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1),
           ($urandom_range(0, 5) == 0), ls, lf);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
